// File: rtl/cpu_ctrl_pkg.sv
// Shared Mini-SRC control definitions: opcodes, phase encoding, ALU one-hot bit indices.
// Latency: none (types and constants only).
// Backpressure: none.
package cpu_ctrl_pkg;

    localparam int FETCH_STEPS = 3;
    localparam int MAX_STEP    = 7;

    localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2,  OP_ADD  = 5'd3;
    localparam logic [4:0] OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_ROR  = 5'd7;
    localparam logic [4:0] OP_ROL  = 5'd8,  OP_SHR  = 5'd9,  OP_SHRA = 5'd10, OP_SHL  = 5'd11;
    localparam logic [4:0] OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14, OP_MUL  = 5'd15;
    localparam logic [4:0] OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18, OP_BR   = 5'd19;
    localparam logic [4:0] OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22, OP_OUT  = 5'd23;
    localparam logic [4:0] OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26, OP_HALT = 5'd27;

    typedef enum logic [1:0] {PH_FETCH, PH_EXEC, PH_HALT} phase_e;

    localparam int ALU_W    = 13;
    localparam int ALU_AND  = 0,  ALU_OR   = 1,  ALU_NEG = 2,  ALU_NOT = 3,  ALU_SUB = 4;
    localparam int ALU_ADD  = 5,  ALU_MUL  = 6,  ALU_ROR = 7,  ALU_DIV = 8,  ALU_SHL = 9;
    localparam int ALU_SHR  = 10, ALU_SHRA = 11, ALU_ROL = 12;

    typedef struct packed {
        logic alu_reg, alu_imm, muldiv, unary, ld, ldi, st, br, jr, jal;
        logic io_in, io_out, mfhi, mflo, nop, halt, illegal;
    } iclass_t;

    typedef struct packed {
        logic PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
        logic IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
        logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15in, conIn, InPortout, outPortin;
        logic [ALU_W-1:0] alu_op;
    } strobe_t;

    function automatic logic [ALU_W-1:0] alu_onehot(input logic [4:0] op);
        logic [ALU_W-1:0] oh;
        oh = '0;
        case (op)
            OP_ADD, OP_ADDI: oh[ALU_ADD]  = 1'b1;
            OP_SUB:          oh[ALU_SUB]  = 1'b1;
            OP_AND, OP_ANDI: oh[ALU_AND]  = 1'b1;
            OP_OR,  OP_ORI:  oh[ALU_OR]   = 1'b1;
            OP_ROR:          oh[ALU_ROR]  = 1'b1;
            OP_ROL:          oh[ALU_ROL]  = 1'b1;
            OP_SHR:          oh[ALU_SHR]  = 1'b1;
            OP_SHRA:         oh[ALU_SHRA] = 1'b1;
            OP_SHL:          oh[ALU_SHL]  = 1'b1;
            OP_MUL:          oh[ALU_MUL]  = 1'b1;
            OP_DIV:          oh[ALU_DIV]  = 1'b1;
            OP_NEG:          oh[ALU_NEG]  = 1'b1;
            OP_NOT:          oh[ALU_NOT]  = 1'b1;
            default:         oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath signal bundle: ir/con/stop in, control strobes out.
// Latency: none (wires only).
// Backpressure: none; strobes are unconditional per cycle.
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con, stop;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write;
    logic        IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15in, conIn, InPortout, outPortin;
    logic [12:0] alu_op;
    logic        run;
`ifdef ILLEGAL_TRAP_EN
    logic        illegal;
`endif

    modport master (
        input  ir, con, stop,
        output PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
        output IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
        output Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15in, conIn, InPortout, outPortin,
`ifdef ILLEGAL_TRAP_EN
        output illegal,
`endif
        output alu_op, run
    );

    modport slave (
        output ir, con, stop,
        input  PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write,
        input  IRin, Yin, Zin, Zlowout, Zhighout, HIin, HIout, LOin, LOout,
        input  Gra, Grb, Grc, Rin, Rout, BAout, Cout, R15in, conIn, InPortout, outPortin,
`ifdef ILLEGAL_TRAP_EN
        input  illegal,
`endif
        input  alu_op, run
    );
endinterface

// File: rtl/opcode_decoder.sv
// Maps the 5-bit opcode to a one-hot instruction class.
// Latency: combinational. Backpressure: none.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output iclass_t    cls
);
    always_comb begin
        cls = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL,
            OP_SHR, OP_SHRA, OP_SHL:   cls.alu_reg = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:  cls.alu_imm = 1'b1;
            OP_MUL, OP_DIV:            cls.muldiv  = 1'b1;
            OP_NEG, OP_NOT:            cls.unary   = 1'b1;
            OP_LD:                     cls.ld      = 1'b1;
            OP_LDI:                    cls.ldi     = 1'b1;
            OP_ST:                     cls.st      = 1'b1;
            OP_BR:                     cls.br      = 1'b1;
            OP_JR:                     cls.jr      = 1'b1;
            OP_JAL:                    cls.jal     = 1'b1;
            OP_IN:                     cls.io_in   = 1'b1;
            OP_OUT:                    cls.io_out  = 1'b1;
            OP_MFHI:                   cls.mfhi    = 1'b1;
            OP_MFLO:                   cls.mflo    = 1'b1;
            OP_NOP:                    cls.nop     = 1'b1;
            OP_HALT:                   cls.halt    = 1'b1;
            default:                   cls.illegal = 1'b1;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Mini-SRC hardwired control: fetch/decode/execute FSM, one micro-step per clock (ILLEGAL_TRAP_EN traps opcodes 28-31).
// Latency: strobes are combinational from {phase, step}, ir and con; state advances every clock.
// Backpressure: none; stop is honoured only at the instruction boundary, HALT exits only via clr.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);
    phase_e   phase_q, phase_d;
    logic [2:0] step_q, step_d, last_step;
    iclass_t  cls;
    strobe_t  s, so;
    logic [ALU_W-1:0] op_alu, add_oh;

    opcode_decoder u_dec (.opcode(bus.ir[31:27]), .cls(cls));

    assign op_alu = alu_onehot(bus.ir[31:27]);
    assign add_oh = alu_onehot(OP_ADD);

    always_comb begin
        last_step = 3'd3;
        if (cls.alu_reg || cls.alu_imm || cls.ldi) last_step = 3'd5;
        else if (cls.muldiv || cls.br)             last_step = 3'd6;
        else if (cls.unary || cls.jal)             last_step = 3'd4;
        else if (cls.ld || cls.st)                 last_step = 3'd7;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
`endif

    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d = illegal_q;
`endif
        case (phase_q)
            PH_FETCH: begin
                if (step_q == 3'(FETCH_STEPS - 1)) phase_d = PH_EXEC;
                step_d = step_q + 3'd1;
            end
            PH_EXEC: begin
                if (step_q == last_step || step_q == 3'(MAX_STEP)) begin
                    step_d = 3'd0;
                    if (cls.halt)      phase_d = PH_HALT;
`ifdef ILLEGAL_TRAP_EN
                    else if (cls.illegal) begin
                        phase_d   = PH_HALT;
                        illegal_d = 1'b1;
                    end
`endif
                    else if (bus.stop) phase_d = PH_HALT;
                    else               phase_d = PH_FETCH;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            default: begin
                phase_d = PH_HALT;
                step_d  = step_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            phase_q <= PH_FETCH;
            step_q  <= 3'd0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    always_comb begin
        s = '0;
        if (phase_q == PH_FETCH) begin
            case (step_q)
                3'd0: begin s.PCout = 1'b1; s.MARin = 1'b1; s.IncPC = 1'b1; s.Zin = 1'b1; end
                3'd1: begin s.Zlowout = 1'b1; s.PCin = 1'b1; s.Read = 1'b1; s.MDRin = 1'b1; end
                3'd2: begin s.MDRout = 1'b1; s.IRin = 1'b1; end
                default: ;
            endcase
        end else if (phase_q == PH_EXEC) begin
            if (cls.alu_reg || cls.alu_imm) begin
                case (step_q)
                    3'd3: begin s.Grb = 1'b1; s.Rout = 1'b1; s.Yin = 1'b1; end
                    3'd4: begin
                        s.Grc = cls.alu_reg; s.Rout = cls.alu_reg; s.Cout = cls.alu_imm;
                        s.alu_op = op_alu; s.Zin = 1'b1;
                    end
                    3'd5: begin s.Zlowout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                    default: ;
                endcase
            end else if (cls.muldiv) begin
                case (step_q)
                    3'd3: begin s.Gra = 1'b1; s.Rout = 1'b1; s.Yin = 1'b1; end
                    3'd4: begin s.Grb = 1'b1; s.Rout = 1'b1; s.alu_op = op_alu; s.Zin = 1'b1; end
                    3'd5: begin s.Zlowout = 1'b1; s.LOin = 1'b1; end
                    3'd6: begin s.Zhighout = 1'b1; s.HIin = 1'b1; end
                    default: ;
                endcase
            end else if (cls.unary) begin
                case (step_q)
                    3'd3: begin s.Grb = 1'b1; s.Rout = 1'b1; s.alu_op = op_alu; s.Zin = 1'b1; end
                    3'd4: begin s.Zlowout = 1'b1; s.Gra = 1'b1; s.Rin = 1'b1; end
                    default: ;
                endcase
            end else if (cls.ld || cls.ldi || cls.st) begin
                // Effective address (base + C) is shared by all three memory forms.
                case (step_q)
                    3'd3: begin s.Grb = 1'b1; s.BAout = 1'b1; s.Yin = 1'b1; end
                    3'd4: begin s.Cout = 1'b1; s.alu_op = add_oh; s.Zin = 1'b1; end
                    3'd5: begin s.Zlowout = 1'b1; s.Gra = cls.ldi; s.Rin = cls.ldi; s.MARin = !cls.ldi; end
                    3'd6: begin
                        s.Read = cls.ld; s.MDRin = 1'b1; s.Gra = cls.st; s.Rout = cls.st;
                    end
                    3'd7: begin
                        s.MDRout = cls.ld; s.Gra = cls.ld; s.Rin = cls.ld; s.Write = cls.st;
                    end
                    default: ;
                endcase
            end else if (cls.br) begin
                case (step_q)
                    3'd3: begin s.Gra = 1'b1; s.Rout = 1'b1; s.conIn = 1'b1; end
                    3'd4: begin s.PCout = 1'b1; s.Yin = 1'b1; end
                    3'd5: begin s.Cout = 1'b1; s.alu_op = add_oh; s.Zin = 1'b1; end
                    3'd6: begin s.Zlowout = bus.con; s.PCin = bus.con; end
                    default: ;
                endcase
            end else if (cls.jr) begin
                if (step_q == 3'd3) begin s.Gra = 1'b1; s.Rout = 1'b1; s.PCin = 1'b1; end
            end else if (cls.jal) begin
                if (step_q == 3'd3) begin s.PCout = 1'b1; s.R15in = 1'b1; end
                if (step_q == 3'd4) begin s.Gra = 1'b1; s.Rout = 1'b1; s.PCin = 1'b1; end
            end else if (cls.nop || cls.halt || cls.illegal) begin
                s = '0;
            end else if (step_q == 3'd3) begin
                s.Gra       = 1'b1;
                s.Rin       = cls.io_in || cls.mfhi || cls.mflo;
                s.Rout      = cls.io_out;
                s.InPortout = cls.io_in;
                s.outPortin = cls.io_out;
                s.HIout     = cls.mfhi;
                s.LOout     = cls.mflo;
            end
        end
    end

    assign so = clr ? s : '0;

    assign bus.PCout = so.PCout;     assign bus.PCin = so.PCin;       assign bus.IncPC = so.IncPC;
    assign bus.MARin = so.MARin;     assign bus.MDRin = so.MDRin;     assign bus.MDRout = so.MDRout;
    assign bus.Read = so.Read;       assign bus.Write = so.Write;     assign bus.IRin = so.IRin;
    assign bus.Yin = so.Yin;         assign bus.Zin = so.Zin;         assign bus.Zlowout = so.Zlowout;
    assign bus.Zhighout = so.Zhighout; assign bus.HIin = so.HIin;     assign bus.HIout = so.HIout;
    assign bus.LOin = so.LOin;       assign bus.LOout = so.LOout;     assign bus.Gra = so.Gra;
    assign bus.Grb = so.Grb;         assign bus.Grc = so.Grc;         assign bus.Rin = so.Rin;
    assign bus.Rout = so.Rout;       assign bus.BAout = so.BAout;     assign bus.Cout = so.Cout;
    assign bus.R15in = so.R15in;     assign bus.conIn = so.conIn;     assign bus.InPortout = so.InPortout;
    assign bus.outPortin = so.outPortin;
    assign bus.alu_op = so.alu_op;
    assign bus.run = clr && (phase_q != PH_HALT);
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal = illegal_q;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: per-instruction micro-step lists model, random programs.
module tb_control_sequencer;
    typedef logic [41:0] vec_t;

    localparam vec_t B_PCOUT = vec_t'(1) << 0,  B_PCIN  = vec_t'(1) << 1,  B_INCPC = vec_t'(1) << 2;
    localparam vec_t B_MARIN = vec_t'(1) << 3,  B_MDRIN = vec_t'(1) << 4,  B_MDROUT = vec_t'(1) << 5;
    localparam vec_t B_READ  = vec_t'(1) << 6,  B_WRITE = vec_t'(1) << 7,  B_IRIN  = vec_t'(1) << 8;
    localparam vec_t B_YIN   = vec_t'(1) << 9,  B_ZIN   = vec_t'(1) << 10, B_ZLOW  = vec_t'(1) << 11;
    localparam vec_t B_ZHIGH = vec_t'(1) << 12, B_HIIN  = vec_t'(1) << 13, B_HIOUT = vec_t'(1) << 14;
    localparam vec_t B_LOIN  = vec_t'(1) << 15, B_LOOUT = vec_t'(1) << 16, B_GRA   = vec_t'(1) << 17;
    localparam vec_t B_GRB   = vec_t'(1) << 18, B_GRC   = vec_t'(1) << 19, B_RIN   = vec_t'(1) << 20;
    localparam vec_t B_ROUT  = vec_t'(1) << 21, B_BAOUT = vec_t'(1) << 22, B_COUT  = vec_t'(1) << 23;
    localparam vec_t B_R15IN = vec_t'(1) << 24, B_CONIN = vec_t'(1) << 25, B_INPORT = vec_t'(1) << 26;
    localparam vec_t B_OUTPORT = vec_t'(1) << 27, B_RUN = vec_t'(1) << 41;
    localparam vec_t BUS_DRV = B_PCOUT | B_MDROUT | B_ZLOW | B_ZHIGH | B_HIOUT | B_LOOUT
                             | B_ROUT | B_COUT | B_INPORT;

    logic clk, clr;
    control_sequencer_if bus();
    control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

    vec_t dut_vec;
    assign dut_vec = {bus.run, bus.alu_op, bus.outPortin, bus.InPortout, bus.conIn, bus.R15in,
                      bus.Cout, bus.BAout, bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra,
                      bus.LOout, bus.LOin, bus.HIout, bus.HIin, bus.Zhighout, bus.Zlowout,
                      bus.Zin, bus.Yin, bus.IRin, bus.Write, bus.Read, bus.MDRout, bus.MDRin,
                      bus.MARin, bus.IncPC, bus.PCin, bus.PCout};

    vec_t exp_q[$];
    vec_t seq_q[$];
    string tag_q[$];
    int n_chk = 0, n_fail = 0;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end

    // ALU one-hot for an opcode, from the op-name -> bit table (AND is bit 0 .. ROL bit 12).
    function automatic vec_t alu(input int op);
        int b;
        case (op)
            3, 12: b = 5;   4: b = 4;   5, 13: b = 0;  6, 14: b = 1;
            7: b = 7;       8: b = 12;  9: b = 10;     10: b = 11;   11: b = 9;
            15: b = 6;      16: b = 8;  17: b = 2;     18: b = 3;
            default: b = -1;
        endcase
        return (b < 0) ? vec_t'(0) : (vec_t'(1) << (28 + b));
    endfunction

    // Full micro-step list of one instruction, fetch included.
    task automatic build(input int op, input logic c);
        vec_t R;
        vec_t A;
        R = B_RUN;
        A = vec_t'(1) << (28 + 5);
        seq_q.delete();
        seq_q.push_back(R | B_PCOUT | B_MARIN | B_INCPC | B_ZIN);
        seq_q.push_back(R | B_ZLOW | B_PCIN | B_READ | B_MDRIN);
        seq_q.push_back(R | B_MDROUT | B_IRIN);
        if (op >= 3 && op <= 11) begin
            seq_q.push_back(R | B_GRB | B_ROUT | B_YIN);
            seq_q.push_back(R | B_GRC | B_ROUT | B_ZIN | alu(op));
            seq_q.push_back(R | B_ZLOW | B_GRA | B_RIN);
        end else if (op >= 12 && op <= 14) begin
            seq_q.push_back(R | B_GRB | B_ROUT | B_YIN);
            seq_q.push_back(R | B_COUT | B_ZIN | alu(op));
            seq_q.push_back(R | B_ZLOW | B_GRA | B_RIN);
        end else if (op == 15 || op == 16) begin
            seq_q.push_back(R | B_GRA | B_ROUT | B_YIN);
            seq_q.push_back(R | B_GRB | B_ROUT | B_ZIN | alu(op));
            seq_q.push_back(R | B_ZLOW | B_LOIN);
            seq_q.push_back(R | B_ZHIGH | B_HIIN);
        end else if (op == 17 || op == 18) begin
            seq_q.push_back(R | B_GRB | B_ROUT | B_ZIN | alu(op));
            seq_q.push_back(R | B_ZLOW | B_GRA | B_RIN);
        end else if (op <= 2) begin
            seq_q.push_back(R | B_GRB | B_BAOUT | B_YIN);
            seq_q.push_back(R | B_COUT | B_ZIN | A);
            if (op == 1) seq_q.push_back(R | B_ZLOW | B_GRA | B_RIN);
            else         seq_q.push_back(R | B_ZLOW | B_MARIN);
            if (op == 0) begin
                seq_q.push_back(R | B_READ | B_MDRIN);
                seq_q.push_back(R | B_MDROUT | B_GRA | B_RIN);
            end else if (op == 2) begin
                seq_q.push_back(R | B_GRA | B_ROUT | B_MDRIN);
                seq_q.push_back(R | B_WRITE);
            end
        end else if (op == 19) begin
            seq_q.push_back(R | B_GRA | B_ROUT | B_CONIN);
            seq_q.push_back(R | B_PCOUT | B_YIN);
            seq_q.push_back(R | B_COUT | B_ZIN | A);
            seq_q.push_back(c ? (R | B_ZLOW | B_PCIN) : R);
        end else if (op == 20) seq_q.push_back(R | B_GRA | B_ROUT | B_PCIN);
        else if (op == 21) begin
            seq_q.push_back(R | B_PCOUT | B_R15IN);
            seq_q.push_back(R | B_GRA | B_ROUT | B_PCIN);
        end
        else if (op == 22) seq_q.push_back(R | B_INPORT | B_GRA | B_RIN);
        else if (op == 23) seq_q.push_back(R | B_GRA | B_ROUT | B_OUTPORT);
        else if (op == 24) seq_q.push_back(R | B_HIOUT | B_GRA | B_RIN);
        else if (op == 25) seq_q.push_back(R | B_LOOUT | B_GRA | B_RIN);
        else seq_q.push_back(R);
    endtask

    task automatic cycle(input vec_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b0;
        cycle('0, "reset");
        cycle('0, "reset");
        clr = 1'b1;
    endtask

    // Runs one instruction; returns 1 when the machine is expected to end in HALT.
    task automatic run_instr(input logic [31:0] irv, input logic c, input logic stp, output logic halted);
        int op;
        int n;
        op = int'(irv[31:27]);
        build(op, c);
        n = seq_q.size();
        bus.con = c;
        for (int i = 0; i < n; i++) begin
            if (i == 3) bus.ir = irv;
            bus.stop = (i == n - 1) ? stp : 1'b0;
            cycle(seq_q[i], $sformatf("op%0d_T%0d", op, i));
        end
        bus.stop = 1'b0;
        halted = stp || (op == 27);
`ifdef ILLEGAL_TRAP_EN
        if (op >= 28) halted = 1'b1;
`endif
    endtask

    task automatic idle_halt(input int n);
        for (int i = 0; i < n; i++) cycle('0, "halt_idle");
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            vec_t e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_chk++;
            if (dut_vec !== e) begin
                n_fail++;
                $display("FAIL %s t=%0t actual=%h required=%h", t, $time, dut_vec, e);
            end
            n_chk++;
            if ($countones(dut_vec & BUS_DRV) > 1) begin
                n_fail++;
                $display("FAIL bus_conflict_%s actual_drivers=%0d required<=1", t,
                         $countones(dut_vec & BUS_DRV));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired actual=running required=finished");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic h;
        logic [4:0] op;
        clr = 1'b0; bus.ir = '0; bus.con = 1'b0; bus.stop = 1'b0;
        @(posedge clk); #1;
        do_reset();
        run_instr(32'h18918000, 1'b0, 1'b0, h);   // add R1,R2,R3
        run_instr(32'h00900055, 1'b0, 1'b0, h);   // ld R1,0x55(R2)
        run_instr(32'h99080014, 1'b1, 1'b0, h);   // br taken
        run_instr(32'h99080014, 1'b0, 1'b0, h);   // br not taken
        run_instr(32'h79A00000, 1'b0, 1'b0, h);   // mul R3,R4
        run_instr(32'h18918000, 1'b0, 1'b1, h);   // add with stop at boundary
        idle_halt(4);
        do_reset();
        run_instr(32'hD8000000, 1'b0, 1'b0, h);   // halt
        idle_halt(20);
        do_reset();
        // st interrupted by clr in the middle of T4
        build(2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.ir = 32'h10800000;
            cycle(seq_q[i], $sformatf("st_T%0d", i));
        end
        #2 clr = 1'b0;
        cycle('0, "st_abort");
        cycle('0, "st_abort");
        clr = 1'b1;
        run_instr(32'hA0800000, 1'b0, 1'b0, h);   // jr
        for (int k = 0; k < 60; k++) begin
            op = 5'($urandom_range(0, 31));
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), h);
            if (h) begin
                idle_halt(int'($urandom_range(1, 3)));
                do_reset();
            end
        end
        @(posedge clk); #1;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
